// File: rtl/uart_sample_assembler.sv
// uart_sample_assembler
//
// Builds 16-bit samples from a byte stream that comes from a UART receiver.
// A frame is four bytes: HEADER, LSB, MSB, CHK, where CHK = LSB ^ MSB.
// When a frame checks out, {MSB,LSB} goes into a single-entry output
// register that uses a valid/ready handshake. If the consumer has not taken
// the previous sample yet, the new sample is dropped and an overflow pulse
// is raised. If the link goes quiet in the middle of a frame, the partial
// frame is abandoned after TIMEOUT_CLKS idle clocks.
//
// Parameters
//   HEADER        frame start byte
//   TIMEOUT_CLKS  idle clocks allowed between bytes inside a frame (2..65535)
//
// Ports
//   in_Clock          clock; all logic is on its rising edge
//   in_Reset          synchronous active-high reset
//   in_Rx_DV          one-cycle strobe; in_Rx_Byte is valid on this cycle
//   in_Rx_Byte        received byte
//   out_Sample_Valid  out_Sample holds a sample that has not been consumed
//   in_Sample_Ready   consumer takes the sample when out_Sample_Valid=1
//   out_Sample        assembled sample {MSB,LSB}
//   out_Chk_Err       one-cycle pulse: checksum mismatch
//   out_Timeout       one-cycle pulse: partial frame abandoned
//   out_Overflow      one-cycle pulse: good frame dropped, output register full
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | hunting for HEADER; other bytes are ignored
// GET_LSB | header seen, next byte is the sample LSB
// GET_MSB | LSB stored, next byte is the sample MSB
// GET_CHK | LSB/MSB stored, next byte is the XOR checksum

module uart_sample_assembler #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 2000
) (
  input  logic        in_Clock,
  input  logic        in_Reset,
  input  logic        in_Rx_DV,
  input  logic [7:0]  in_Rx_Byte,
  output logic        out_Sample_Valid,
  input  logic        in_Sample_Ready,
  output logic [15:0] out_Sample,
  output logic        out_Chk_Err,
  output logic        out_Timeout,
  output logic        out_Overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_LSB = 2'd1,
    GET_MSB = 2'd2,
    GET_CHK = 2'd3
  } state_t;

  // Terminal count of the inter-byte idle counter.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  lsb, lsb_nxt;
  logic [7:0]  msb, msb_nxt;

  logic        frame_done;
  logic        chk_bad;
  logic        to_hit;
  logic        sample_load;
  logic        sample_drop;
  logic        valid_nxt;

  // Shared handling for the three in-frame states. When no byte arrives,
  // the counter runs toward TO_LAST. A byte that arrives on the
  // terminal-count cycle still wins, because the byte path is checked first.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lsb_nxt    = lsb;
    msb_nxt    = msb;
    frame_done = 1'b0;
    chk_bad    = 1'b0;
    to_hit     = 1'b0;

    if (state == IDLE) begin
      cnt_nxt = 16'h0000;
      if (in_Rx_DV && (in_Rx_Byte == HEADER)) begin
        state_nxt = GET_LSB;
      end
    end else if (in_Rx_DV) begin
      cnt_nxt = 16'h0000;
      case (state)
        GET_LSB: begin
          lsb_nxt   = in_Rx_Byte;
          state_nxt = GET_MSB;
        end
        GET_MSB: begin
          msb_nxt   = in_Rx_Byte;
          state_nxt = GET_CHK;
        end
        GET_CHK: begin
          state_nxt = IDLE;
          if (in_Rx_Byte == (lsb ^ msb)) begin
            frame_done = 1'b1;
          end else begin
            chk_bad = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (cnt == TO_LAST) begin
      to_hit    = 1'b1;
      cnt_nxt   = 16'h0000;
      state_nxt = IDLE;
    end else begin
      cnt_nxt = cnt + 16'd1;
    end
  end

  // Output register handshake. A consumer handshake on the same cycle frees
  // the register, so the new sample can be loaded straight away.
  always_comb begin
    sample_load = frame_done && (!out_Sample_Valid || in_Sample_Ready);
    sample_drop = frame_done && out_Sample_Valid && !in_Sample_Ready;
    valid_nxt   = out_Sample_Valid;
    if (sample_load) begin
      valid_nxt = 1'b1;
    end else if (out_Sample_Valid && in_Sample_Ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      state            <= IDLE;
      cnt              <= 16'h0000;
      lsb              <= 8'h00;
      msb              <= 8'h00;
      out_Sample       <= 16'h0000;
      out_Sample_Valid <= 1'b0;
      out_Chk_Err      <= 1'b0;
      out_Timeout      <= 1'b0;
      out_Overflow     <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      lsb              <= lsb_nxt;
      msb              <= msb_nxt;
      out_Sample_Valid <= valid_nxt;
      out_Chk_Err      <= chk_bad;
      out_Timeout      <= to_hit;
      out_Overflow     <= sample_drop;
      if (sample_load) begin
        // The MSB of the frame is the CHK-state byte's predecessor, which
        // is already in msb; lsb_nxt equals lsb in GET_CHK.
        out_Sample <= {msb, lsb};
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_assembler.sv
module tb_uart_sample_assembler;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  rx_byte;
  logic        valid;
  logic        ready;
  logic [15:0] sample;
  logic        chk_err;
  logic        timeout;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_sample_assembler #(.HEADER(HDR), .TIMEOUT_CLKS(TO)) dut (
    .in_Clock        (clk),
    .in_Reset        (rst),
    .in_Rx_DV        (dv),
    .in_Rx_Byte      (rx_byte),
    .out_Sample_Valid(valid),
    .in_Sample_Ready (ready),
    .out_Sample      (sample),
    .out_Chk_Err     (chk_err),
    .out_Timeout     (timeout),
    .out_Overflow    (overflow)
  );

  // Reference model: the frame in progress is a byte queue, and the gap
  // since the last byte is an integer.
  logic [7:0]  m_frame[$];
  int          m_idle;
  logic        m_valid;
  logic [15:0] m_sample;
  logic        m_chk, m_to, m_ovf;

  task automatic model_step(input logic r, input logic d, input logic [7:0] b,
                            input logic rd);
    logic complete;
    logic [15:0] new_s;
    complete = 1'b0;
    new_s    = 16'h0;
    m_chk = 1'b0; m_to = 1'b0; m_ovf = 1'b0;
    if (r) begin
      m_frame.delete();
      m_idle = 0; m_valid = 1'b0; m_sample = 16'h0;
      return;
    end
    if (m_frame.size() == 0) begin
      m_idle = 0;
      if (d && b == HDR) m_frame.push_back(b);
    end else if (d) begin
      m_frame.push_back(b);
      m_idle = 0;
      if (m_frame.size() == 4) begin
        if (m_frame[3] == (m_frame[1] ^ m_frame[2])) begin
          complete = 1'b1;
          new_s = {m_frame[2], m_frame[1]};
        end else begin
          m_chk = 1'b1;
        end
        m_frame.delete();
      end
    end else if (m_idle == TO - 1) begin
      m_frame.delete();
      m_idle = 0;
      m_to = 1'b1;
    end else begin
      m_idle++;
    end
    if (complete) begin
      if (!m_valid || rd) begin
        m_sample = new_s;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic d, input logic [7:0] b, input logic rd);
    rst = r; dv = d; rx_byte = b; ready = rd;
    @(posedge clk);
    model_step(r, d, b, rd);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},    16'(valid),    16'(m_valid));
    chk({tag, ".sample"},   sample,        m_sample);
    chk({tag, ".chk_err"},  16'(chk_err),  16'(m_chk));
    chk({tag, ".timeout"},  16'(timeout),  16'(m_to));
    chk({tag, ".overflow"}, 16'(overflow), 16'(m_ovf));
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] b,
                      input logic rd, input string tag);
    tick(r, d, b, rd);
    check_model(tag);
  endtask

  typedef struct {
    logic        rst;
    logic        dv;
    logic [7:0]  b;
    logic        rdy;
    logic        valid;
    logic [15:0] sample;
    logic        chk;
    logic        to;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  initial begin
    rst = 1'b1; dv = 1'b0; rx_byte = 8'h00; ready = 1'b0;
    m_idle = 0; m_valid = 1'b0; m_sample = 16'h0;
    m_chk = 1'b0; m_to = 1'b0; m_ovf = 1'b0;

    // Each row gives the inputs for one edge and the outputs seen after it.
    vq.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h26, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    // HEADER value inside a frame is data
    vq.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0});

    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].dv, vq[i].b, vq[i].rdy);
      chk($sformatf("vec%0d.valid", i),    16'(valid),    16'(vq[i].valid));
      chk($sformatf("vec%0d.sample", i),   sample,        vq[i].sample);
      chk($sformatf("vec%0d.chk_err", i),  16'(chk_err),  16'(vq[i].chk));
      chk($sformatf("vec%0d.timeout", i),  16'(timeout),  16'(vq[i].to));
      chk($sformatf("vec%0d.overflow", i), 16'(overflow), 16'(vq[i].ovf));
    end

    // Timeout: A5,34 followed by TO quiet cycles
    step(0, 1, 8'hA5, 1, "to_a");
    step(0, 1, 8'h34, 1, "to_b");
    for (int i = 0; i < TO - 1; i++) begin
      tick(0, 0, 8'h00, 1);
      chk("to_early", 16'(timeout), 16'h0);
    end
    tick(0, 0, 8'h00, 1);
    chk("to_pulse", 16'(timeout), 16'h1);
    tick(0, 0, 8'h00, 1);
    chk("to_single", 16'(timeout), 16'h0);
    step(0, 1, 8'hA5, 1, "to_c");
    step(0, 1, 8'h01, 1, "to_d");
    step(0, 1, 8'hA5, 1, "to_e");
    tick(0, 1, 8'hA4, 1);
    chk("to_sample", sample, 16'hA501);
    chk("to_valid", 16'(valid), 16'h1);
    step(0, 0, 8'h00, 1, "to_f");

    // A byte that arrives on the terminal-count cycle is consumed and does
    // not cause a timeout
    step(0, 1, 8'hA5, 1, "tc_a");
    for (int i = 0; i < TO - 1; i++) step(0, 0, 8'h00, 1, "tc_idle");
    tick(0, 1, 8'h07, 1);
    chk("tc_no_to", 16'(timeout), 16'h0);
    step(0, 0, 8'h00, 1, "tc_after");
    chk("tc_no_to2", 16'(timeout), 16'h0);
    step(0, 1, 8'h00, 1, "tc_msb");
    tick(0, 1, 8'h07, 1);
    chk("tc_sample", sample, 16'h0007);
    step(0, 0, 8'h00, 1, "tc_end");

    // Overflow while the consumer stalls
    step(0, 1, 8'hA5, 0, "ov"); step(0, 1, 8'h01, 0, "ov");
    step(0, 1, 8'h00, 0, "ov"); step(0, 1, 8'h01, 0, "ov");
    chk("ov_first", sample, 16'h0001);
    step(0, 1, 8'hA5, 0, "ov"); step(0, 1, 8'h02, 0, "ov");
    step(0, 1, 8'h00, 0, "ov");
    tick(0, 1, 8'h02, 0);
    chk("ov_pulse", 16'(overflow), 16'h1);
    chk("ov_held", sample, 16'h0001);
    tick(0, 0, 8'h00, 0);
    chk("ov_single", 16'(overflow), 16'h0);
    chk("ov_still_valid", 16'(valid), 16'h1);
    // Frame completes on the same edge as the handshake
    step(0, 1, 8'hA5, 0, "sim"); step(0, 1, 8'h04, 0, "sim");
    step(0, 1, 8'h00, 0, "sim");
    tick(0, 1, 8'h04, 1);
    chk("sim_valid", 16'(valid), 16'h1);
    chk("sim_sample", sample, 16'h0004);
    chk("sim_no_ovf", 16'(overflow), 16'h0);
    tick(0, 0, 8'h00, 1);
    chk("sim_clear", 16'(valid), 16'h0);

    // Reset in the middle of a frame, with a strobe on the reset edge
    step(0, 1, 8'hA5, 1, "rs"); step(0, 1, 8'h34, 1, "rs");
    tick(1, 1, 8'h12, 1);
    chk("rs_valid", 16'(valid), 16'h0);
    chk("rs_sample", sample, 16'h0000);
    step(0, 1, 8'h12, 1, "rs_after");
    step(0, 1, 8'h26, 1, "rs_after");
    chk("rs_no_sample", 16'(valid), 16'h0);

    // Randomized frames, corruption, gaps and backpressure
    for (int f = 0; f < 400; f++) begin
      logic [7:0] fb[4];
      fb[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : HDR;
      fb[1] = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (fb[1] ^ fb[2]);
      for (int k = 0; k < 4; k++) begin
        int gap;
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1)
                                          : $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          step(0, 0, 8'($urandom), 1'($urandom_range(0, 1)), "rnd_gap");
        step(($urandom_range(0, 299) == 0), 1, fb[k],
             1'($urandom_range(0, 2) != 0), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
